// File: rtl/jtframe_dwnld_pkg.sv
// Shared types for the ROM download packer: FIFO entry layout, byte masks,
// write FSM states and the per-entry byte sum used by the optional checksum.
package jtframe_dwnld_pkg;

    // prog_mask bit set means that byte lane is not written
    localparam logic [1:0] MASK_NONE = 2'b00;
    localparam logic [1:0] MASK_LO   = 2'b10;  // only low byte valid
    localparam logic [1:0] MASK_HI   = 2'b01;  // only high byte valid

    typedef struct packed {
        logic [1:0]  ba;
        logic [21:0] addr;
        logic [15:0] data;
        logic [1:0]  mask;
    } entry_t;

    typedef enum logic [1:0] { IDLE, WRITE, GAP } wr_st_t;

    // Sum of the byte lanes an entry actually writes
    function automatic logic [15:0] entry_sum(input entry_t e);
        entry_sum = (e.mask[0] ? 16'd0 : {8'd0, e.data[7:0]})
                  + (e.mask[1] ? 16'd0 : {8'd0, e.data[15:8]});
    endfunction

endpackage

// File: rtl/jtframe_dwnld_fifo.sv
// Word FIFO for the download packer. Accepts up to two entries per cycle
// (din0 first) and one pop; the caller never pushes beyond free space.
module jtframe_dwnld_fifo
    import jtframe_dwnld_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   push_n,
    input  entry_t       din0,
    input  entry_t       din1,
    input  logic         pop,
    output entry_t       dout,
    output logic [AW:0]  level,
    output logic         full,
    output logic         empty
);
    localparam logic [AW-1:0] ONE = AW'(1);

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    // Storage: no reset needed, validity is tracked by level
    always_ff @(posedge clk) begin
        if (push_n != 2'd0) mem[wr_ptr] <= din0;
        if (push_n == 2'd2) mem[wr_ptr + ONE] <= din1;
    end

    // Pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push_n);
            rd_ptr <= rd_ptr + AW'(pop);
            level  <= level + (AW+1)'(push_n) - (AW+1)'(pop);
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = level == (AW+1)'(DEPTH);
    assign empty = level == '0;

endmodule

// File: rtl/jtframe_dwnld_pack.sv
// ROM download packer: pairs ioctl bytes into 16-bit SDRAM words, splits the
// byte address into bank + word offset, queues words and writes them with a
// prog_we/prog_rdy handshake followed by a one-cycle gap.
// Optional: JTFRAME_DWNLD_CHECKSUM_EN enables the 16-bit byte sum on dwnld_sum.
module jtframe_dwnld_pack
    import jtframe_dwnld_pkg::*;
#(
    parameter logic [24:0] BA1_START  = 25'h040000,
    parameter logic [24:0] BA2_START  = 25'h080000,
    parameter logic [24:0] BA3_START  = 25'h0C0000,
    parameter int          FIFO_DEPTH = 4
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        downloading,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        ioctl_rom_wr,
    output logic [21:0] prog_addr,
    output logic [15:0] prog_data,
    output logic [1:0]  prog_mask,
    output logic [1:0]  prog_ba,
    output logic        prog_we,
    input  logic        prog_rdy,
    output logic        dwnld_busy,
    output logic        overflow,
    output logic [15:0] dwnld_sum
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = AW + 2;

    wr_st_t      state;
    logic        dl_d, rise, fall, wr, pop, drop;
    logic [1:0]  ba, need, n_push;
    logic [22:0] base, offset;
    logic [21:0] waddr;
    logic        odd, match;
    logic        pend_vld, pend_set, pend_clr;
    logic [1:0]  pend_ba;
    logic [21:0] pend_addr;
    logic [7:0]  pend_data;
    entry_t      flush_e, lone_e, pair_e, e0, e1, head;
    logic [AW:0] fifo_level;
    logic        fifo_full, fifo_empty;
    logic [FW-1:0] free;

    assign wr   = downloading & ioctl_rom_wr;
    assign rise = downloading & ~dl_d;
    assign fall = ~downloading & dl_d;
    assign pop  = (state == WRITE) && prog_rdy;

    // Bank select: highest bank whose start the address has reached
    always_comb begin
        ba   = 2'd0;
        base = 23'd0;
        if (ioctl_addr >= BA3_START) begin
            ba = 2'd3; base = BA3_START[22:0];
        end else if (ioctl_addr >= BA2_START) begin
            ba = 2'd2; base = BA2_START[22:0];
        end else if (ioctl_addr >= BA1_START) begin
            ba = 2'd1; base = BA1_START[22:0];
        end
        offset = ioctl_addr[22:0] - base;
    end

    assign waddr   = offset[22:1];
    assign odd     = offset[0];
    assign match   = pend_vld && pend_ba == ba && pend_addr == waddr;
    assign flush_e = {pend_ba, pend_addr, 8'd0, pend_data, MASK_LO};
    assign lone_e  = {ba, waddr, ioctl_data, 8'd0, MASK_HI};
    assign pair_e  = {ba, waddr, ioctl_data, pend_data, MASK_NONE};
    // A pop this cycle frees its slot for a same-cycle push
    assign free    = fifo_full ? FW'(pop)
                   : FW'(FIFO_DEPTH) - FW'(fifo_level) + FW'(pop);

    // Decide which entries this cycle wants to push; older flush goes first
    always_comb begin
        need     = 2'd0;
        e0       = '0;
        e1       = '0;
        pend_set = 1'b0;
        pend_clr = 1'b0;
        if (wr) begin
            if (odd) begin
                pend_clr = 1'b1;
                if (match) begin
                    e0 = pair_e; need = 2'd1;
                end else if (pend_vld) begin
                    e0 = flush_e; e1 = lone_e; need = 2'd2;
                end else begin
                    e0 = lone_e; need = 2'd1;
                end
            end else begin
                pend_set = 1'b1;
                if (pend_vld) begin
                    e0 = flush_e; need = 2'd1;
                end
            end
        end else if (fall && pend_vld) begin
            e0 = flush_e; need = 2'd1; pend_clr = 1'b1;
        end
        drop   = FW'(need) > free;
        n_push = drop ? free[1:0] : need;
    end

    jtframe_dwnld_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_n (n_push),
        .din0   (e0),
        .din1   (e1),
        .pop    (pop),
        .dout   (head),
        .level  (fifo_level),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Pending even byte waiting for its odd partner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld  <= 1'b0;
            pend_ba   <= 2'd0;
            pend_addr <= 22'd0;
            pend_data <= 8'd0;
        end else if (pend_set) begin
            pend_vld  <= 1'b1;
            pend_ba   <= ba;
            pend_addr <= waddr;
            pend_data <= ioctl_data;
        end else if (pend_clr) begin
            pend_vld  <= 1'b0;
        end
    end

    // Write FSM: present FIFO head, hold until accepted, then one idle gap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            prog_we   <= 1'b0;
            prog_addr <= 22'd0;
            prog_data <= 16'd0;
            prog_mask <= 2'b11;
            prog_ba   <= 2'd0;
        end else begin
            case (state)
                IDLE: if (!fifo_empty) begin
                    state     <= WRITE;
                    prog_we   <= 1'b1;
                    prog_addr <= head.addr;
                    prog_data <= head.data;
                    prog_mask <= head.mask;
                    prog_ba   <= head.ba;
                end
                WRITE: if (prog_rdy) begin
                    state   <= GAP;
                    prog_we <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Edge history of downloading and the sticky drop flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_d     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            dl_d     <= downloading;
            overflow <= (rise ? 1'b0 : overflow) | drop;
        end
    end

`ifdef JTFRAME_DWNLD_CHECKSUM_EN
    logic [15:0] sum, sum_add;

    assign sum_add = (n_push != 2'd0 ? entry_sum(e0) : 16'd0)
                   + (n_push == 2'd2 ? entry_sum(e1) : 16'd0);

    // Running sum of bytes that made it into the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sum <= 16'd0;
        else        sum <= (rise ? 16'd0 : sum) + sum_add;
    end

    assign dwnld_sum = sum;
`else
    assign dwnld_sum = 16'd0;
`endif

    assign dwnld_busy = rst_n & (downloading | pend_vld | ~fifo_empty | (state != IDLE));

endmodule

// File: doc/jtframe_dwnld_pack.md
JTFRAME_DWNLD_PACK -- requirements
Module: jtframe_dwnld_pack

Interface
REQ-001 SHALL have parameter BA1_START, default 25'h040000, first byte address mapped to SDRAM bank 1.
REQ-002 SHALL have parameter BA2_START, default 25'h080000, first byte address mapped to bank 2.
REQ-003 SHALL have parameter BA3_START, default 25'h0C0000, first byte address mapped to bank 3.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, power of two, word-entry count.
REQ-005 SHALL have one clock and asynchronous active-low reset: clk input 1 (rising edge, clk_rom domain); rst_n input 1 (async assert, active low).
REQ-006 SHALL have the following download-side ports: downloading input 1 (ROM download in progress); ioctl_addr input 25 (byte address); ioctl_data input 8 (byte); ioctl_rom_wr input 1 (one-cycle byte strobe).
REQ-007 SHALL have the following SDRAM-side ports: prog_addr output 22 (word offset in bank); prog_data output 16; prog_mask output 2 (active high = byte NOT written; bit0 low byte); prog_ba output 2; prog_we output 1; prog_rdy input 1 (write accepted).
REQ-008 SHALL have the following status ports: dwnld_busy output 1; overflow output 1 (sticky byte drop); dwnld_sum output 16.

Function
REQ-009 SHALL select bank by comparing byte address: >=BA3_START ->3, >=BA2_START ->2, >=BA1_START ->1, else 0, with offset = address minus that bank start.
REQ-010 SHALL place even-offset bytes in prog_data[7:0] and odd-offset bytes in [15:8], with prog_addr = offset[22:1].
REQ-011 SHALL hold an even byte as pending; a following odd byte with the same bank and word address SHALL push one entry with mask 2'b00.
REQ-012 SHALL push a lone-byte entry for any strobe not completing the pending word: mask 2'b10 for a pending even byte flushed; mask 2'b01 for an odd byte with no matching pending.
REQ-013 SHALL push the pending even byte with mask 2'b10 on the falling edge of downloading.
REQ-014 SHALL have a push-to-present latency of one cycle: byte strobe at cycle N pushes at N+1 and, with the FIFO empty, drives prog_we high at N+2.
REQ-015 SHALL implement a write FSM with states IDLE, WRITE, GAP: IDLE->WRITE when the FIFO is non-empty; WRITE holds prog_we=1 with stable addr/data/mask/ba until prog_rdy=1, then pops and goes to GAP; GAP drives prog_we=0 for exactly one cycle, then goes to IDLE.
REQ-016 SHALL handle a push with the FIFO full by dropping the byte(s), setting overflow, and leaving the FIFO contents intact; a simultaneous pop and push when full SHALL succeed.
REQ-017 SHALL, when a flush and a completing push are required in one cycle with only one free entry, push the flush entry and set overflow.
REQ-018 SHALL drive dwnld_busy = downloading OR pending OR FIFO non-empty OR state!=IDLE, so that it falls the cycle after the last GAP.
REQ-019 SHALL clear overflow on the rising edge of downloading.
REQ-020 SHALL ignore ioctl_rom_wr when downloading=0.

Reset
REQ-021 SHALL, on rst_n low, immediately set: FIFO empty, pending cleared, state IDLE, prog_we=0, prog_addr/prog_data=0, prog_mask=2'b11, prog_ba=0, overflow=0, dwnld_sum=0, dwnld_busy=0.
REQ-022 SHALL, on reset mid-transfer, discard all queued words without issuing further writes.

Configuration
REQ-023 SHALL, with JTFRAME_DWNLD_CHECKSUM_EN defined, keep dwnld_sum as a 16-bit wrap-around sum of every accepted byte (dropped bytes excluded), cleared on the rising edge of downloading.
REQ-024 SHALL, without JTFRAME_DWNLD_CHECKSUM_EN, drive dwnld_sum constant 0 and synthesise no adder.

Structure
REQ-025 SHALL place the entry typedef {ba[1:0], addr[21:0], data[15:0], mask[1:0]} and constants MASK_NONE=2'b00, MASK_LO=2'b10, MASK_HI=2'b01 in package jtframe_dwnld_pkg.
REQ-026 SHALL implement the FIFO as sub-module jtframe_dwnld_fifo (synchronous, full/empty flags, simultaneous push/pop).

Verification
REQ-027 SHALL verify pairing: bytes 0x12@0, 0x34@1, prog_rdy=1 -> one write ba=0 addr=0 data=16'h3412 mask=00, prog_we high exactly at cycle N+2.
REQ-028 SHALL verify bank split: bytes 0xAA@25'h040000, 0xBB@25'h040001 -> ba=1 addr=0 data=16'hBBAA.
REQ-029 SHALL verify odd-length flush: 3 bytes from 0, then downloading falls -> second write addr=1 mask=10; dwnld_busy low one cycle after its GAP.
REQ-030 SHALL verify backpressure: prog_rdy=0 while 12 bytes are streamed -> FIFO fills at 4 words, overflow=1, first 4 words later written intact in order.
REQ-031 SHALL verify reset: rst_n low while prog_we=1 -> prog_we=0 and dwnld_busy=0 immediately, no write after release.
REQ-032 SHALL verify the checksum (macro defined): bytes 0xFF,0x02 -> dwnld_sum=16'h0101; new download start -> 0.
